tick_scheduler: RTL and testbench

//  Multi-channel event scheduler driven by the tick generator's tick_o strobe.

---
 rtl/tick_scheduler.sv | 162 ++++++++++++++++
 tb/tb_tick_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//   Multi-channel periodic event scheduler. Each channel counts base ticks up to
//   a programmable period. When a channel expires it is marked pending. Pending
//   channels are granted round-robin onto a single registered valid/ready event
//   port, so several periodic tasks share one timebase and one consumer.
//
//   Optional feature macro: TICK_SCHED_OVERRUN_EN
//     defined   : sticky per-channel overrun flags, cleared by overrun_clr_i
//                 (a set in the same cycle as the clear wins)
//     undefined : overrun_o tied to 0, overrun_clr_i ignored
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   tick_i         base tick strobe, one cycle wide
//   enable_i       per-channel run enable (disabled channel holds count at 0)
//   cfg_we_i       period write strobe
//   cfg_ch_i       channel addressed by the write (out-of-range ignored)
//   cfg_period_i   new period in ticks, 0 = never expires
//   evt_valid_o    event available
//   evt_ch_o       channel of the presented event
//   evt_ready_i    consumer accepts the presented event
//   overrun_o      sticky per-channel overrun flags
//   overrun_clr_i  clear all overrun flags
// -----------------------------------------------------------------------------
module tick_scheduler #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned PERIOD_W = 16,
    localparam int unsigned CH_W    = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                tick_i,
    input  logic [N_CH-1:0]     enable_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    output logic                evt_valid_o,
    output logic [CH_W-1:0]     evt_ch_o,
    input  logic                evt_ready_i,
    output logic [N_CH-1:0]     overrun_o,
    input  logic                overrun_clr_i
);

    logic [PERIOD_W-1:0] period_q [N_CH];
    logic [PERIOD_W-1:0] period_d [N_CH];
    logic [PERIOD_W-1:0] cnt_q    [N_CH];
    logic [PERIOD_W-1:0] cnt_d    [N_CH];

    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] cfg_hit, expire, grant_clr, overrun;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] grant_ch, scan_ch;
    logic            grant_found, slot_free;
    logic            evt_valid_q, evt_valid_d;
    logic [CH_W-1:0] evt_ch_q, evt_ch_d;

    // Per-channel period/counter update. A config write to a channel beats the
    // tick increment and suppresses its expiry in the same cycle.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            cfg_hit[c]  = cfg_we_i && (cfg_ch_i == CH_W'(c));
            period_d[c] = cfg_hit[c] ? cfg_period_i : period_q[c];
            cnt_d[c]    = cnt_q[c];
            expire[c]   = 1'b0;
            if (cfg_hit[c] || !enable_i[c]) begin
                cnt_d[c] = '0;
            end else if (tick_i && (period_q[c] != '0)) begin
                if (cnt_q[c] == period_q[c] - PERIOD_W'(1)) begin
                    cnt_d[c]  = '0;
                    expire[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + PERIOD_W'(1);
                end
            end
        end
    end

    // Round-robin search: first pending channel at rr_ptr, rr_ptr+1, ... mod N_CH.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        scan_ch     = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_ch = CH_W'((32'(rr_ptr_q) + 32'(i)) % N_CH);
            if (!grant_found && pending_q[scan_ch]) begin
                grant_found = 1'b1;
                grant_ch    = scan_ch;
            end
        end
    end

    // Output slot and pending bookkeeping.
    always_comb begin
        slot_free   = !evt_valid_q || evt_ready_i;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_ptr_d    = rr_ptr_q;
        grant_clr   = '0;
        if (slot_free) begin
            evt_valid_d = grant_found;
            if (grant_found) begin
                evt_ch_d  = grant_ch;
                grant_clr = N_CH'(1) << grant_ch;
                rr_ptr_d  = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            end
        end
        // An expiry coinciding with the grant of the same channel re-arms it
        // instead of counting as an overrun.
        overrun   = expire & pending_q & ~grant_clr;
        pending_d = (pending_q & ~grant_clr) | expire;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < N_CH; c++) begin
                period_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                period_q[c] <= period_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_ch_o    = evt_ch_q;

`ifdef TICK_SCHED_OVERRUN_EN
    logic [N_CH-1:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = (overrun_clr_i ? '0 : overrun_q) | overrun;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    logic unused_overrun;
    assign unused_overrun = overrun_clr_i ^ (|overrun);
    assign overrun_o      = '0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    localparam int N  = 4;
    localparam int PW = 16;
    localparam int CW = 2;

`ifdef TICK_SCHED_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic [N-1:0]  enable;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [PW-1:0] cfg_period;
    logic          evt_valid;
    logic [CW-1:0] evt_ch;
    logic          evt_ready;
    logic [N-1:0]  overrun;
    logic          overrun_clr;

    int n_checks = 0;
    int n_errors = 0;
    int acc [N] = '{0, 0, 0, 0};

    tick_scheduler #(.N_CH(N), .PERIOD_W(PW)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .tick_i       (tick),
        .enable_i     (enable),
        .cfg_we_i     (cfg_we),
        .cfg_ch_i     (cfg_ch),
        .cfg_period_i (cfg_period),
        .evt_valid_o  (evt_valid),
        .evt_ch_o     (evt_ch),
        .evt_ready_i  (evt_ready),
        .overrun_o    (overrun),
        .overrun_clr_i(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [N-1:0][PW-1:0] period;
        logic [N-1:0][PW-1:0] cnt;
        logic [N-1:0]         pend;
        logic [N-1:0]         ovr;
        int                   rr;
        logic                 valid;
        int                   ch;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(input mstate_t s);
        mstate_t      n;
        logic [N-1:0] expired;
        int           g;
        bit           free;
        n       = s;
        expired = '0;
        g       = -1;
        for (int c = 0; c < N; c++) begin
            bit wr;
            wr = cfg_we && (int'(cfg_ch) == c);
            if (wr || !enable[c]) begin
                n.cnt[c] = '0;
            end else if (tick && s.period[c] != 0) begin
                if (int'(s.cnt[c]) + 1 == int'(s.period[c])) begin
                    n.cnt[c]   = '0;
                    expired[c] = 1'b1;
                end else begin
                    n.cnt[c] = s.cnt[c] + 16'd1;
                end
            end
            if (wr) n.period[c] = cfg_period;
        end
        free = !s.valid || evt_ready;
        if (free) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && s.pend[(s.rr + k) % N]) g = (s.rr + k) % N;
            end
            n.valid = (g >= 0);
            if (g >= 0) begin
                n.ch      = g;
                n.pend[g] = 1'b0;
                n.rr      = (g + 1) % N;
            end
        end
        if (OVR_EN) begin
            if (overrun_clr) n.ovr = '0;
            for (int c = 0; c < N; c++) begin
                if (expired[c] && s.pend[c] && g != c) n.ovr[c] = 1'b1;
            end
        end
        n.pend = n.pend | expired;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= step(m);
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("evt_valid", int'(evt_valid), int'(m.valid));
            if (m.valid) check("evt_ch", int'(evt_ch), m.ch);
            check("overrun", int'(overrun), int'(m.ovr));
        end
    end

    // Accepted-event counter per channel.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) acc[evt_ch] <= acc[evt_ch] + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic cfg(input int ch, input int p);
        cfg_we     = 1'b1;
        cfg_ch     = CW'(ch);
        cfg_period = PW'(p);
        cyc();
        cfg_we     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        cyc();
    endtask

    function automatic int total_acc();
        int t = 0;
        for (int c = 0; c < N; c++) t += acc[c];
        return t;
    endfunction

    initial begin
        int base;
        reset       = 1'b1;
        tick        = 1'b0;
        enable      = '0;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_period  = '0;
        evt_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", int'(evt_valid), 0);
        check("reset_ch", int'(evt_ch), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        cyc();

        // 1: period 3 on ch0, nine ticks, three events each two cycles after tick
        cfg(0, 3);
        enable    = 4'b0001;
        evt_ready = 1'b1;
        base      = acc[0];
        for (int k = 1; k <= 9; k++) begin
            do_tick();
            if (k % 3 == 0) begin
                @(negedge clk);
                check("t1_lat_t1", int'(evt_valid), 0);
                cyc();
                @(negedge clk);
                check("t1_lat_t2_valid", int'(evt_valid), 1);
                check("t1_lat_t2_ch", int'(evt_ch), 0);
            end
            cyc();
        end
        wait_n(4);
        check("t1_count", acc[0] - base, 3);

        // 2: all periods 1, one tick -> ch0..3 back to back
        do_reset();
        for (int c = 0; c < N; c++) cfg(c, 1);
        enable    = 4'b1111;
        evt_ready = 1'b1;
        do_tick();
        @(negedge clk);
        check("t2_first_gap", int'(evt_valid), 0);
        for (int c = 0; c < N; c++) begin
            cyc();
            @(negedge clk);
            check("t2_b2b_valid", int'(evt_valid), 1);
            check("t2_b2b_ch", int'(evt_ch), c);
        end
        cyc();
        @(negedge clk);
        check("t2_drained", int'(evt_valid), 0);
        do_tick();
        cyc();
        @(negedge clk);
        check("t2_rr_wrap_ch", int'(evt_ch), 0);
        wait_n(6);

        // 3: held event on ch2 stays stable, re-expiry re-issued once
        do_reset();
        cfg(2, 2);
        enable    = 4'b0100;
        evt_ready = 1'b0;
        base      = acc[2];
        do_tick();
        do_tick();
        cyc();
        @(negedge clk);
        check("t3_present_ch", int'(evt_ch), 2);
        for (int j = 0; j < 5; j++) begin
            cyc();
            tick = (j < 2);
            @(negedge clk);
            check("t3_hold_valid", int'(evt_valid), 1);
            check("t3_hold_ch", int'(evt_ch), 2);
        end
        cyc();
        tick = 1'b0;
        check("t3_no_overrun", int'(overrun), 0);
        evt_ready = 1'b1;
        cyc();
        @(negedge clk);
        check("t3_reissue_valid", int'(evt_valid), 1);
        check("t3_reissue_ch", int'(evt_ch), 2);
        cyc();
        @(negedge clk);
        check("t3_done", int'(evt_valid), 0);
        wait_n(4);
        check("t3_count", acc[2] - base, 2);

        // 4: overrun on ch1 with consumer stalled
        do_reset();
        cfg(1, 1);
        enable    = 4'b0010;
        evt_ready = 1'b0;
        base      = acc[1];
        do_tick();
        wait_n(2);
        do_tick();
        cyc();
        do_tick();
        cyc();
        @(negedge clk);
        check("t4_overrun", int'(overrun), OVR_EN ? 2 : 0);
        cyc();
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        @(negedge clk);
        check("t4_overrun_clr", int'(overrun), 0);
        cyc();
        evt_ready = 1'b1;
        wait_n(6);
        check("t4_count", acc[1] - base, 2);

        // 5: config write on the expiring tick cancels expiry, restarts count
        do_reset();
        cfg(0, 3);
        enable    = 4'b0001;
        evt_ready = 1'b1;
        base      = acc[0];
        do_tick();
        do_tick();
        tick       = 1'b1;
        cfg_we     = 1'b1;
        cfg_ch     = 2'd0;
        cfg_period = 16'd5;
        cyc();
        tick   = 1'b0;
        cfg_we = 1'b0;
        wait_n(4);
        check("t5_no_event", acc[0] - base, 0);
        for (int k = 0; k < 4; k++) begin
            do_tick();
            cyc();
        end
        wait_n(3);
        check("t5_not_yet", acc[0] - base, 0);
        do_tick();
        wait_n(4);
        check("t5_fifth_tick", acc[0] - base, 1);

        // 6: async reset while an event is presented
        do_reset();
        cfg(0, 1);
        cfg(1, 1);
        enable    = 4'b0011;
        evt_ready = 1'b0;
        do_tick();
        wait_n(2);
        @(negedge clk);
        check("t6_pre_valid", int'(evt_valid), 1);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", int'(evt_valid), 0);
        check("t6_async_ch", int'(evt_ch), 0);
        check("t6_async_overrun", int'(overrun), 0);
        reset     = 1'b0;
        evt_ready = 1'b1;
        base      = total_acc();
        wait_n(6);
        check("t6_no_stale", total_acc() - base, 0);
        do_tick();
        wait_n(4);
        check("t6_periods_cleared", total_acc() - base, 0);

        // Randomised phase, checked every cycle by the model comparison.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            tick        = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) enable = N'($urandom);
            cfg_we      = ($urandom_range(0, 5) == 0);
            cfg_ch      = CW'($urandom);
            cfg_period  = PW'($urandom_range(0, 5));
            evt_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 19) == 0);
        end
        tick   = 1'b0;
        cfg_we = 1'b0;
        wait_n(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
